// File: rtl/ft_pkg.sv
// ft_pkg: definitions shared by the FT245 TX arbiter and the RX decoder.
//   - ft_state_e   : packet framing states (IDLE, HDR, PAYLOAD, CRC)
//   - header layout: {sync[3:0], pad[2:0], source id[0]}
//   - source IDs   : SRC0_ID / SRC1_ID
//   - helpers to build and split a header byte
package ft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } ft_state_e;

  localparam int         HDR_SYNC_W = 4;
  localparam int         HDR_PAD_W  = 3;
  localparam logic [2:0] HDR_PAD    = 3'b000;

  localparam logic SRC0_ID = 1'b0;
  localparam logic SRC1_ID = 1'b1;

  function automatic logic [7:0] ft_make_hdr(input logic [3:0] sync, input logic id);
    return {sync, HDR_PAD, id};
  endfunction

  function automatic logic [3:0] ft_hdr_sync(input logic [7:0] hdr);
    return hdr[7:4];
  endfunction

  function automatic logic ft_hdr_id(input logic [7:0] hdr);
    return hdr[0];
  endfunction

endpackage

// File: rtl/ft_tx_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request per source
//   en         : commit the current grant as the new last-grant
//   gnt_id     : index of the source that wins right now
//   any_req    : at least one request is present
// After reset last-grant is source 1, so source 0 wins the first tie.
module rr_arb2
  import ft_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_id,
  output logic       any_req
);

  logic last_q;

  always_comb begin
    gnt_id = SRC0_ID;
    if (req == 2'b11)
      gnt_id = ~last_q;
    else if (req[1])
      gnt_id = SRC1_ID;
  end

  assign any_req = |req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_q <= SRC1_ID;
    else if (en)
      last_q <= gnt_id;
  end

endmodule

// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter: merges two byte-stream sources into one FT245 TX FIFO.
// Each packet is framed as a header byte {HDR_SYNC, 3'b000, source id}
// followed by the payload; packets longer than MAX_LEN are cut at MAX_LEN
// bytes and len_err latches until reset.
// Optional build macro FT_TX_CHECKSUM_EN appends an XOR-of-payload trailer.
// Ports:
//   clk, rst_n                        : FT245 clock, async active-low reset
//   src0_/src1_ valid,data,last,ready : source byte streams (valid/ready)
//   tx_wdata, tx_winc, tx_wfull       : TX FIFO write side
//   len_err                           : sticky truncation flag
module ft_tx_arbiter
  import ft_pkg::*;
#(
  parameter logic [3:0] HDR_SYNC = 4'hA,
  parameter int         MAX_LEN  = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       src0_valid,
  input  logic [7:0] src0_data,
  input  logic       src0_last,
  output logic       src0_ready,
  input  logic       src1_valid,
  input  logic [7:0] src1_data,
  input  logic       src1_last,
  output logic       src1_ready,
  output logic [7:0] tx_wdata,
  output logic       tx_winc,
  input  logic       tx_wfull,
  output logic       len_err
);

  localparam logic [8:0] LAST_IDX = 9'(MAX_LEN - 1);

  ft_state_e  state_q, state_d;
  logic       grant_q;
  logic [8:0] cnt_q;
  logic       len_err_q;
  logic       gnt_id, any_req, arb_en;
  logic       sel_valid, sel_last;
  logic [7:0] sel_data;
  logic       xfer, max_hit, pkt_end;

  // Arbitration only happens in IDLE; the grant is then frozen for the packet.
  assign arb_en = (state_q == ST_IDLE) && any_req;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({src1_valid, src0_valid}),
    .en      (arb_en),
    .gnt_id  (gnt_id),
    .any_req (any_req)
  );

  assign sel_valid = grant_q ? src1_valid : src0_valid;
  assign sel_data  = grant_q ? src1_data  : src0_data;
  assign sel_last  = grant_q ? src1_last  : src0_last;

  assign xfer    = (state_q == ST_PAYLOAD) && sel_valid && !tx_wfull;
  // cnt_q holds bytes already sent, so this transfer is byte number MAX_LEN.
  assign max_hit = (cnt_q == LAST_IDX);
  assign pkt_end = xfer && (sel_last || max_hit);

`ifdef FT_TX_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      csum_q <= 8'h00;
    else if (arb_en)
      csum_q <= 8'h00;
    else if (xfer)
      csum_q <= csum_q ^ sel_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= SRC0_ID;
      cnt_q     <= 9'd0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arb_en) begin
        grant_q <= gnt_id;
        cnt_q   <= 9'd0;
      end else if (xfer) begin
        cnt_q <= cnt_q + 9'd1;
      end
      if (pkt_end && !sel_last)
        len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;

  // Outputs are decoded from state so an async reset clears them at once.
  always_comb begin
    state_d    = state_q;
    tx_wdata   = 8'h00;
    tx_winc    = 1'b0;
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req)
          state_d = ST_HDR;
      end
      ST_HDR: begin
        tx_wdata = ft_make_hdr(HDR_SYNC, grant_q);
        tx_winc  = !tx_wfull;
        if (!tx_wfull)
          state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        tx_wdata   = sel_data;
        tx_winc    = sel_valid && !tx_wfull;
        src0_ready = (grant_q == SRC0_ID) && !tx_wfull;
        src1_ready = (grant_q == SRC1_ID) && !tx_wfull;
        if (pkt_end) begin
`ifdef FT_TX_CHECKSUM_EN
          state_d = ST_CRC;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_CRC: begin
`ifdef FT_TX_CHECKSUM_EN
        tx_wdata = csum_q;
        tx_winc  = !tx_wfull;
        if (!tx_wfull)
          state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Scoreboard bench for ft_tx_arbiter (MAX_LEN = 4 so truncation is reachable).
module tb_ft_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       src0_valid, src0_last, src0_ready;
  logic [7:0] src0_data;
  logic       src1_valid, src1_last, src1_ready;
  logic [7:0] src1_data;
  logic [7:0] tx_wdata;
  logic       tx_winc;
  logic       tx_wfull;
  logic       len_err;

  always #5 clk = ~clk;

  ft_tx_arbiter #(.HDR_SYNC(4'hA), .MAX_LEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src0_valid (src0_valid),
    .src0_data  (src0_data),
    .src0_last  (src0_last),
    .src0_ready (src0_ready),
    .src1_valid (src1_valid),
    .src1_data  (src1_data),
    .src1_last  (src1_last),
    .src1_ready (src1_ready),
    .tx_wdata   (tx_wdata),
    .tx_winc    (tx_winc),
    .tx_wfull   (tx_wfull),
    .len_err    (len_err)
  );

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_wr  = 0;
  logic [7:0] csum_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input int src, input logic [7:0] d, input logic last);
    if (src == 0) q0.push_back({last, d});
    else          q1.push_back({last, d});
  endtask

  task automatic exp_hdr(input int src);
    sb.push_back({4'hA, 3'b000, src[0]});
    csum_acc = 8'h00;
  endtask

  task automatic exp_byte(input logic [7:0] d);
    sb.push_back(d);
    csum_acc = csum_acc ^ d;
  endtask

  task automatic exp_end();
`ifdef FT_TX_CHECKSUM_EN
    sb.push_back(csum_acc);
`endif
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && q0.size() == 0 && q1.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Source drivers: handshake sampled at negedge, queue advanced after posedge.
  initial begin
    logic f0, f1;
    logic [8:0] tmp;
    src0_valid = 1'b0; src0_data = 8'h00; src0_last = 1'b0;
    src1_valid = 1'b0; src1_data = 8'h00; src1_last = 1'b0;
    forever begin
      @(negedge clk);
      f0 = src0_valid && src0_ready;
      f1 = src1_valid && src1_ready;
      @(posedge clk);
      #1;
      if (f0 && q0.size() > 0) tmp = q0.pop_front();
      if (f1 && q1.size() > 0) tmp = q1.pop_front();
      src0_valid = (q0.size() > 0);
      {src0_last, src0_data} = (q0.size() > 0) ? q0[0] : 9'h000;
      src1_valid = (q1.size() > 0);
      {src1_last, src1_data} = (q1.size() > 0) ? q1[0] : 9'h000;
    end
  end

  // Monitor: every FIFO write is popped against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_wfull) begin
          check("winc_while_full", {31'd0, tx_winc}, 32'd0);
          check("ready_while_full", {30'd0, src1_ready, src0_ready}, 32'd0);
        end else if (tx_winc) begin
          n_wr++;
          if (sb.size() == 0) begin
            check("unexpected_write", {24'd0, tx_wdata}, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("wdata", {24'd0, tx_wdata}, {24'd0, e});
          end
        end
      end
    end
  end

  initial begin
    int base;
    logic ok;
    tx_wfull = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_winc",   {31'd0, tx_winc}, 32'd0);
    check("rst_wdata",  {24'd0, tx_wdata}, 32'd0);
    check("rst_ready",  {30'd0, src1_ready, src0_ready}, 32'd0);
    check("rst_len_err", {31'd0, len_err}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Simultaneous 1-byte packets: src0 wins first after reset.
    @(posedge clk); #2;
    drv(0, 8'h5A, 1'b1); drv(1, 8'hC3, 1'b1);
    exp_hdr(0); exp_byte(8'h5A); exp_end();
    exp_hdr(1); exp_byte(8'hC3); exp_end();
    wait_drain("drain_pair1");

    // src0 alone, leaves last-grant on src0.
    @(posedge clk); #2;
    drv(0, 8'hF0, 1'b0); drv(0, 8'h0F, 1'b0); drv(0, 8'hAA, 1'b1);
    exp_hdr(0); exp_byte(8'hF0); exp_byte(8'h0F); exp_byte(8'hAA); exp_end();
    wait_drain("drain_f00faa");

    // Tie again: src1 now goes first.
    @(posedge clk); #2;
    drv(0, 8'h5A, 1'b1); drv(1, 8'hC3, 1'b1);
    exp_hdr(1); exp_byte(8'hC3); exp_end();
    exp_hdr(0); exp_byte(8'h5A); exp_end();
    wait_drain("drain_pair2");

    // src1 alone, 3 bytes.
    @(posedge clk); #2;
    drv(1, 8'h11, 1'b0); drv(1, 8'h22, 1'b0); drv(1, 8'h33, 1'b1);
    exp_hdr(1); exp_byte(8'h11); exp_byte(8'h22); exp_byte(8'h33); exp_end();
    wait_drain("drain_src1");

    // FIFO full for 4 cycles mid-payload.
    base = n_wr;
    @(posedge clk); #2;
    drv(0, 8'h10, 1'b0); drv(0, 8'h20, 1'b0); drv(0, 8'h30, 1'b1);
    exp_hdr(0); exp_byte(8'h10); exp_byte(8'h20); exp_byte(8'h30); exp_end();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_wr >= base + 2) begin ok = 1'b1; break; end
    end
    check("wait_first_byte", {31'd0, ok}, 32'd1);
    @(posedge clk); #2 tx_wfull = 1'b1;
    repeat (4) @(posedge clk);
    #2 tx_wfull = 1'b0;
    @(negedge clk);
    check("winc_after_full", {31'd0, tx_winc}, 32'd1);
    wait_drain("drain_full");

    // Truncation at MAX_LEN = 4.
    check("len_err_before", {31'd0, len_err}, 32'd0);
    base = n_wr;
    @(posedge clk); #2;
    for (int i = 1; i <= 6; i++) drv(0, 8'(i), (i == 6));
    exp_hdr(0);
    for (int i = 1; i <= 4; i++) exp_byte(8'(i));
    exp_end();
    exp_hdr(0); exp_byte(8'h05); exp_byte(8'h06); exp_end();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_wr >= base + 5) begin ok = 1'b1; break; end
    end
    check("wait_byte04", {31'd0, ok}, 32'd1);
    check("len_err_at_04", {31'd0, len_err}, 32'd0);
    @(negedge clk);
    check("len_err_after_04", {31'd0, len_err}, 32'd1);
    wait_drain("drain_trunc");
    check("len_err_sticky", {31'd0, len_err}, 32'd1);

    // Async reset while src0 packet is stalled in payload.
    @(posedge clk); #2;
    drv(0, 8'h77, 1'b0);
    exp_hdr(0); exp_byte(8'h77);
    wait_drain("drain_pre_reset");
    check("ready_pre_reset", {31'd0, src0_ready}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    q0.delete();
    #1;
    check("arst_winc",    {31'd0, tx_winc}, 32'd0);
    check("arst_wdata",   {24'd0, tx_wdata}, 32'd0);
    check("arst_ready",   {30'd0, src1_ready, src0_ready}, 32'd0);
    check("arst_len_err", {31'd0, len_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    drv(0, 8'h7E, 1'b1);
    exp_hdr(0); exp_byte(8'h7E); exp_end();
    wait_drain("drain_post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
